// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the register file slice.
package reg_file_pkg;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits tracking outstanding multi-cycle producers.
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_all,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] read_addr1,
   input  logic [ADDR_W-1:0] read_addr2,
   output logic              read_busy1,
   output logic              read_busy2
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [NREGS-1:0] busy;

   // Set is applied after clear so a re-issued producer keeps the entry busy.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_all) begin
         busy <= '0;
      end else begin
         if (clr_en) busy[clr_addr] <= 1'b0;
         if (set_en && !(ZERO_REG && set_addr == '0)) busy[set_addr] <= 1'b1;
      end
   end

   function automatic logic busy_lookup(input logic [NREGS-1:0]  bits,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic              wr,
                                        input logic [ADDR_W-1:0] wr_addr,
                                        input logic              st,
                                        input logic [ADDR_W-1:0] st_addr);
      logic retiring;
      retiring = BYPASS && wr && (wr_addr == addr) && !(st && st_addr == addr);
      if (ZERO_REG && addr == '0) return 1'b0;
      return bits[addr] && !retiring;
   endfunction

   assign read_busy1 = busy_lookup(busy, read_addr1, clr_en, clr_addr, set_en, set_addr);
   assign read_busy2 = busy_lookup(busy, read_addr2, clr_en, clr_addr, set_en, set_addr);

endmodule

// File: rtl/reg_file_sb.sv
// Register file with async reads, write bypass, busy scoreboard and a
// one-entry-per-cycle clear engine.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] read_addr1,
   input  logic [ADDR_W-1:0] read_addr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              read_busy1,
   output logic              read_busy2,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic              write_enable,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_addr,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              write_drop
);

   localparam int                NREGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);

   state_t            state;
   logic [ADDR_W-1:0] count;
   logic [DATA_W-1:0] mem [NREGS];
   logic              idle;
   logic              start;
   logic              write_ok;
   logic              write_keep;

   // The IDLE->CLEAR transition cycle already rejects writes.
   assign idle       = (state == IDLE);
   assign start      = idle && clear_start;
   assign write_ok   = write_enable && idle && !clear_start;
   assign write_keep = write_ok && !(ZERO_REG && write_addr == '0);

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] stored,
                                                   input logic              wr,
                                                   input logic [ADDR_W-1:0] wr_addr,
                                                   input logic [DATA_W-1:0] wr_data);
      if (ZERO_REG && addr == '0) return '0;
      if (BYPASS && wr && wr_addr == addr) return wr_data;
      return stored;
   endfunction

   assign read_data1 = read_port(read_addr1, mem[read_addr1], write_ok, write_addr, write_data);
   assign read_data2 = read_port(read_addr2, mem[read_addr2], write_ok, write_addr, write_data);
   assign clear_busy = (state == CLEAR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         write_drop <= 1'b0;
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else begin
         write_drop <= write_enable && !write_ok;
         case (state)
            IDLE: begin
               if (clear_start) begin
                  state <= CLEAR;
                  count <= '0;
               end else if (write_keep) begin
                  mem[write_addr] <= write_data;
               end
            end
            CLEAR: begin
               mem[count] <= '0;
               count      <= count + 1'b1;
               if (count == LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   reg_file_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_all  (start),
      .set_en     (busy_set && idle),
      .set_addr   (busy_addr),
      .clr_en     (write_ok),
      .clr_addr   (write_addr),
      .read_addr1 (read_addr1),
      .read_addr2 (read_addr2),
      .read_busy1 (read_busy1),
      .read_busy2 (read_busy2)
   );

endmodule
